// File: rtl/spi_receiver_if.sv
// Word output channel of the SPI receiver: one assembled word at a time,
// its index within the current frame, and a valid/ready handshake.
interface spi_receiver_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int INDEX_WIDTH = 11
);
   logic [DATA_WIDTH-1:0]  data_out;
   logic                   data_valid;
   logic                   data_ready;
   logic [INDEX_WIDTH-1:0] word_index;

   // Receiver side: produces words, consumes ready
   modport master (
      output data_out,
      output data_valid,
      output word_index,
      input  data_ready
   );

   // Consumer side (frame buffer writer)
   modport slave (
      input  data_out,
      input  data_valid,
      input  word_index,
      output data_ready
   );
endinterface

// File: rtl/spi_receiver.sv
// SPI slave receiver, mode 0, LSB first. The external SCLK/MOSI/CS_n pins are
// oversampled on the system clock through 2-FF synchronizers; SCLK and CS_n get
// a third stage for edge detection. Completed words are offered on a
// valid/ready channel; frame start/end, overrun and truncated-word events are
// reported as single-cycle pulses. DATA_WIDTH must be at least 2.
module spi_receiver #(
   parameter int DATA_WIDTH  = 8,
   parameter int INDEX_WIDTH = 11
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_spi_clock,
   input  logic               i_spi_mosi,
   input  logic               i_spi_cs_n,
   spi_receiver_if.master     o_word_if,
   output logic               o_frame_start,
   output logic               o_frame_end,
   output logic               o_overrun,
   output logic               o_frame_error
);

   localparam int BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_CNT_WIDTH-1:0] LAST_BIT  = BIT_CNT_WIDTH'(DATA_WIDTH - 1);
   localparam logic [BIT_CNT_WIDTH-1:0] BIT_ZERO  = {BIT_CNT_WIDTH{1'b0}};
   localparam logic [BIT_CNT_WIDTH-1:0] BIT_ONE   = {{(BIT_CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [INDEX_WIDTH-1:0]   INDEX_MAX = {INDEX_WIDTH{1'b1}};
   localparam logic [INDEX_WIDTH-1:0]   INDEX_ONE = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};

   // Synchronizer stages (s3 only where an edge is needed)
   logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
   logic r_mosi_s1, r_mosi_s2;
   logic r_cs_s1,   r_cs_s2,   r_cs_s3;

   // Word assembly and frame bookkeeping
   logic [BIT_CNT_WIDTH-1:0] r_bit_count;
   logic [DATA_WIDTH-1:0]    r_shift;
   logic [INDEX_WIDTH-1:0]   r_word_count;

   // Registered outputs
   logic [DATA_WIDTH-1:0]    r_data_out;
   logic                     r_data_valid;
   logic [INDEX_WIDTH-1:0]   r_word_index;
   logic                     r_frame_start;
   logic                     r_frame_end;
   logic                     r_overrun;
   logic                     r_frame_error;

   logic                     w_sclk_rise;
   logic                     w_cs_fall;
   logic                     w_cs_rise;
   logic                     w_cs_event;
   logic                     w_sample;
   logic                     w_word_done;
   logic                     w_slot_free;
   logic [DATA_WIDTH-1:0]    w_assembled;
   logic [INDEX_WIDTH-1:0]   w_count_next;

   assign w_sclk_rise  = r_sclk_s2 & ~r_sclk_s3;
   assign w_cs_fall    = ~r_cs_s2 & r_cs_s3;
   assign w_cs_rise    = r_cs_s2 & ~r_cs_s3;
   assign w_cs_event   = w_cs_fall | w_cs_rise;
   // A CS transition in the same cycle as an SCLK rise suppresses that sample.
   assign w_sample     = w_sclk_rise & ~r_cs_s2 & ~w_cs_event;
   assign w_word_done  = w_sample & (r_bit_count == LAST_BIT);
   // New bit enters at the MSB; after DATA_WIDTH shifts the first bit sits at [0].
   assign w_assembled  = {r_mosi_s2, r_shift[DATA_WIDTH-1:1]};
   // Slot is free if empty, or if the held word is being accepted this cycle.
   assign w_slot_free  = ~r_data_valid | o_word_if.data_ready;
   assign w_count_next = (r_word_count == INDEX_MAX) ? r_word_count
                                                     : r_word_count + INDEX_ONE;

   // Bring the asynchronous SPI pins into the clock domain
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_s3 <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
         r_cs_s1   <= 1'b1;
         r_cs_s2   <= 1'b1;
         r_cs_s3   <= 1'b1;
      end else begin
         r_sclk_s1 <= i_spi_clock;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_s3 <= r_sclk_s2;
         r_mosi_s1 <= i_spi_mosi;
         r_mosi_s2 <= r_mosi_s1;
         r_cs_s1   <= i_spi_cs_n;
         r_cs_s2   <= r_cs_s1;
         r_cs_s3   <= r_cs_s2;
      end
   end

   // Bit shifting, frame word counting and frame boundary pulses
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_bit_count   <= BIT_ZERO;
         r_shift       <= {DATA_WIDTH{1'b0}};
         r_word_count  <= {INDEX_WIDTH{1'b0}};
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_frame_error <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         r_frame_end   <= 1'b0;
         r_frame_error <= 1'b0;
         if (w_cs_fall) begin
            r_frame_start <= 1'b1;
            r_word_count  <= {INDEX_WIDTH{1'b0}};
            r_bit_count   <= BIT_ZERO;
            r_shift       <= {DATA_WIDTH{1'b0}};
         end else if (w_cs_rise) begin
            // Releasing CS with bits in flight truncates the word
            r_frame_end   <= 1'b1;
            r_frame_error <= (r_bit_count != BIT_ZERO);
            r_bit_count   <= BIT_ZERO;
            r_shift       <= {DATA_WIDTH{1'b0}};
         end else if (w_sample) begin
            r_shift <= w_assembled;
            if (w_word_done) begin
               r_bit_count  <= BIT_ZERO;
               r_word_count <= w_count_next;
            end else begin
               r_bit_count <= r_bit_count + BIT_ONE;
            end
         end else begin
            r_bit_count <= r_bit_count;
         end
      end
   end

   // Output slot: load completed words, run the handshake, flag overruns
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_data_out   <= {DATA_WIDTH{1'b0}};
         r_data_valid <= 1'b0;
         r_word_index <= {INDEX_WIDTH{1'b0}};
         r_overrun    <= 1'b0;
      end else begin
         r_overrun <= 1'b0;
         if (w_word_done) begin
            if (w_slot_free) begin
               r_data_out   <= w_assembled;
               r_data_valid <= 1'b1;
               r_word_index <= r_word_count;
            end else begin
               // Held word is not yet consumed: the new one is dropped
               r_overrun <= 1'b1;
            end
         end else if (r_data_valid && o_word_if.data_ready) begin
            r_data_valid <= 1'b0;
         end else begin
            r_data_valid <= r_data_valid;
         end
      end
   end

   assign o_word_if.data_out   = r_data_out;
   assign o_word_if.data_valid = r_data_valid;
   assign o_word_if.word_index = r_word_index;
   assign o_frame_start        = r_frame_start;
   assign o_frame_end          = r_frame_end;
   assign o_overrun            = r_overrun;
   assign o_frame_error        = r_frame_error;

endmodule
